mipi_frame_crop: RTL and testbench

Region-of-interest crop and frame-geometry monitor that sits directly downstream of the CSI-2 deserializer on `img_clk`. It consumes the deserializer's pixel stream (`dati`/`dvi`/`lvi`/`fvi`) and forwards only the pixels inside a programmable window, with regenerated line and frame valids. It also measures the incoming line width, frame height and frame count for host readback.

---
 rtl/mipi_pkg.sv | 18 +
 rtl/mipi_frame_crop_if.sv | 26 ++
 rtl/mipi_win_cmp.sv | 22 ++
 rtl/mipi_frame_crop.sv | 160 ++++++++++++++++
 tb/tb_mipi_frame_crop.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mipi_pkg.sv
// Shared types and constants for the frame-crop block: FSM states, counter width, saturating increment.
// Latency: none (definitions only).
// Backpressure: none; the pixel stream is push-only.
package mipi_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_WAIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Counters stick at all-ones rather than wrapping to a small, plausible-looking value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mipi_frame_crop_if.sv
// Pixel stream bundle: deserializer-side inputs (dati/dvi/lvi/fvi) and cropped outputs (dato/dvo/lvo/fvo).
// Latency: none (wires only).
// Backpressure: none; valids are qualifiers, there is no ready.
// Modports: master = stream source / consumer of the cropped stream; slave = the crop block.
interface mipi_frame_crop_if #(
    parameter int DATA_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] dati;
    logic                  dvi;
    logic                  lvi;
    logic                  fvi;
    logic [DATA_WIDTH-1:0] dato;
    logic                  dvo;
    logic                  lvo;
    logic                  fvo;

    modport master (
        output dati, dvi, lvi, fvi,
        input  dato, dvo, lvo, fvo
    );

    modport slave (
        input  dati, dvi, lvi, fvi,
        output dato, dvo, lvo, fvo
    );
endinterface

// File: rtl/mipi_win_cmp.sv
// Window membership test: start <= cnt < start+len, with len==0 meaning "unbounded".
// Latency: combinational.
// Backpressure: none.
// Ports: cnt (current index), start, len (window), in_win (index is inside the window).
module mipi_win_cmp
    import mipi_pkg::*;
(
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] len,
    output logic             in_win
);

    // One extra bit so start+len can never wrap back below cnt.
    logic [CNT_W:0] stop;

    always_comb begin
        stop   = {1'b0, start} + {1'b0, len};
        in_win = (cnt >= start) && ((len == '0) || ({1'b0, cnt} < stop));
    end

endmodule

// File: rtl/mipi_frame_crop.sv
// ROI crop of the CSI-2 pixel stream with regenerated valids, plus line/frame geometry measurement.
// Latency: 1 img_clk for data and all three valids; measurements update 1 cycle after the closing fall.
// Backpressure: none; the stream cannot be stalled, pixels outside the window are dropped.
// Ports: img_clk/resetb, enable, pix (stream bundle), x/y start/len window, meas_width/meas_height/frame_count/geom_valid.
module mipi_frame_crop
    import mipi_pkg::*;
#(
    parameter int DATA_WIDTH = 10
)(
    input  logic             img_clk,
    input  logic             resetb,
    input  logic             enable,
    mipi_frame_crop_if.slave pix,
    input  logic [CNT_W-1:0] x_start,
    input  logic [CNT_W-1:0] x_len,
    input  logic [CNT_W-1:0] y_start,
    input  logic [CNT_W-1:0] y_len,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] meas_height,
    output logic [CNT_W-1:0] frame_count,
    output logic             geom_valid
);

    state_t state, state_nxt;

    logic lvi_d, fvi_d;
    // Clear for the first edge after reset so that an fvi already high at release
    // does not look like a rise: the block must never enter mid-frame.
    logic primed;

    logic [CNT_W-1:0] x_cnt, y_cnt;
    logic [CNT_W-1:0] xs_q, xl_q, ys_q, yl_q;

    logic [DATA_WIDTH-1:0] dato_q;
    logic                  dvo_q, lvo_q, fvo_q;

    logic lv_rise, lv_fall, fv_rise, fv_fall;
    logic entering, active, in_frame, line_end, pix_acc;
    logic [CNT_W-1:0] xs_eff, xl_eff, ys_eff, yl_eff;
    logic [CNT_W-1:0] x_idx, y_idx, x_nxt, y_nxt;
    logic x_in, y_in, keep, lvo_nxt;

    always_comb begin
        lv_rise = primed &  pix.lvi & ~lvi_d;
        lv_fall = primed & ~pix.lvi &  lvi_d;
        fv_rise = primed &  pix.fvi & ~fvi_d;
        fv_fall = primed & ~pix.fvi &  fvi_d;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT:   if (enable && fv_rise) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!enable || fv_fall) state_nxt = ST_WAIT;
            default:   state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        entering = (state == ST_WAIT) && (state_nxt == ST_ACTIVE);
        // Outputs follow the state being entered, giving fvo exactly 1 cycle after fvi.
        active   = (state_nxt == ST_ACTIVE);
        in_frame = (state == ST_ACTIVE) && enable;

        // The shadows load on the entry edge, so the entry cycle itself sees live config.
        xs_eff = entering ? x_start : xs_q;
        xl_eff = entering ? x_len   : xl_q;
        ys_eff = entering ? y_start : ys_q;
        yl_eff = entering ? y_len   : yl_q;

        // Index of the pixel/line presented this cycle; a pixel on the lvi rise is index 0.
        x_idx = (entering || lv_rise) ? '0 : x_cnt;
        y_idx = entering ? '0 : y_cnt;

        pix_acc  = pix.dvi & pix.lvi;
        line_end = in_frame & (lv_fall | (fv_fall & lvi_d));

        x_nxt = pix_acc  ? sat_inc(x_idx) : x_idx;
        y_nxt = line_end ? sat_inc(y_idx) : y_idx;
    end

    mipi_win_cmp u_x_win (
        .cnt    (x_idx),
        .start  (xs_eff),
        .len    (xl_eff),
        .in_win (x_in)
    );

    mipi_win_cmp u_y_win (
        .cnt    (y_idx),
        .start  (ys_eff),
        .len    (yl_eff),
        .in_win (y_in)
    );

    always_comb begin
        keep    = active & pix_acc & x_in & y_in;
        lvo_nxt = active & pix.lvi & y_in;
    end

    always_ff @(posedge img_clk or negedge resetb) begin
        if (!resetb) begin
            state       <= ST_WAIT;
            primed      <= 1'b0;
            lvi_d       <= 1'b0;
            fvi_d       <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            xs_q        <= '0;
            xl_q        <= '0;
            ys_q        <= '0;
            yl_q        <= '0;
            dato_q      <= '0;
            dvo_q       <= 1'b0;
            lvo_q       <= 1'b0;
            fvo_q       <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            frame_count <= '0;
            geom_valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            primed <= 1'b1;
            lvi_d  <= pix.lvi;
            fvi_d  <= pix.fvi;

            if (entering) begin
                xs_q <= x_start;
                xl_q <= x_len;
                ys_q <= y_start;
                yl_q <= y_len;
            end

            if (active) begin
                x_cnt <= x_nxt;
                y_cnt <= y_nxt;
            end

            if (line_end) meas_width <= x_cnt;

            // y_nxt already includes a line closed on this same cycle.
            if (in_frame && fv_fall) begin
                meas_height <= y_nxt;
                frame_count <= frame_count + 1'b1;
                geom_valid  <= 1'b1;
            end

            dvo_q <= keep;
            lvo_q <= lvo_nxt;
            fvo_q <= active;
            if (keep) dato_q <= pix.dati;
        end
    end

    assign pix.dato = dato_q;
    assign pix.dvo  = dvo_q;
    assign pix.lvo  = lvo_q;
    assign pix.fvo  = fvo_q;

endmodule

// File: tb/tb_mipi_frame_crop.sv
// Directed bench for mipi_frame_crop: frames are driven cycle by cycle, outputs sampled 1ns after each edge.
// Latency: checked as 1 cycle on unwindowed frames.
// Backpressure: none to exercise.
module tb_mipi_frame_crop;

    logic        img_clk = 1'b0;
    logic        resetb;
    logic        enable;
    logic [15:0] x_start, x_len, y_start, y_len;
    logic [15:0] meas_width, meas_height, frame_count;
    logic        geom_valid;

    mipi_frame_crop_if #(.DATA_WIDTH(10)) pix ();

    mipi_frame_crop #(.DATA_WIDTH(10)) dut (
        .img_clk     (img_clk),
        .resetb      (resetb),
        .enable      (enable),
        .pix         (pix),
        .x_start     (x_start),
        .x_len       (x_len),
        .y_start     (y_start),
        .y_len       (y_len),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .frame_count (frame_count),
        .geom_valid  (geom_valid)
    );

    always #5 img_clk = ~img_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-frame observations.
    int         n_dvo, n_lvo, n_fvo;
    logic [9:0] outq[$];
    logic       lvo_prev = 1'b0, fvo_prev = 1'b0;

    // Previous-cycle drive, for the 1-cycle latency check.
    logic       chk_lat = 1'b0;
    logic       dis_chk = 1'b0;
    logic [9:0] p_d = '0;
    logic       p_dv = 1'b0, p_lv = 1'b0, p_fv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample what the previous drive produced, then drive the next inputs.
    task automatic cyc(input logic [9:0] d, input logic dv, input logic lv, input logic fv);
        @(posedge img_clk);
        #1;
        if (pix.dvo === 1'b1) begin
            n_dvo++;
            outq.push_back(pix.dato);
        end
        if (pix.lvo === 1'b1 && !lvo_prev) n_lvo++;
        if (pix.fvo === 1'b1 && !fvo_prev) n_fvo++;
        lvo_prev = (pix.lvo === 1'b1);
        fvo_prev = (pix.fvo === 1'b1);
        if (chk_lat) begin
            chk("lat_dvo", 32'(pix.dvo), 32'(p_dv & p_lv));
            chk("lat_lvo", 32'(pix.lvo), 32'(p_lv));
            chk("lat_fvo", 32'(pix.fvo), 32'(p_fv));
            if (p_dv && p_lv) chk("lat_dato", 32'(pix.dato), 32'(p_d));
        end
        if (dis_chk) begin
            chk("dis_dvo", 32'(pix.dvo), 32'd0);
            chk("dis_lvo", 32'(pix.lvo), 32'd0);
            chk("dis_fvo", 32'(pix.fvo), 32'd0);
            dis_chk = 1'b0;
        end
        pix.dati = d;
        pix.dvi  = dv;
        pix.lvi  = lv;
        pix.fvi  = fv;
        p_d = d; p_dv = dv; p_lv = lv; p_fv = fv;
    endtask

    // Frame of `lines` x `ppl` pixels, data = line*16+pixel, one idle dvi gap after pixel 3.
    // ev_kind at (ev_line, pixel 2): 1 enable on, 2 enable off, 3 x_start->5, 4 reset pulse.
    task automatic run_frame(input int lines, input int ppl, input bit simul,
                             input int ev_line, input int ev_kind);
        n_dvo = 0; n_lvo = 0; n_fvo = 0;
        outq.delete();
        cyc(10'd0, 1'b0, 1'b0, 1'b0);
        cyc(10'd0, 1'b0, 1'b0, 1'b0);
        cyc(10'd0, 1'b0, 1'b0, 1'b1);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < ppl; p++) begin
                if (l == ev_line && p == 2) begin
                    case (ev_kind)
                        1: enable = 1'b1;
                        2: begin enable = 1'b0; dis_chk = 1'b1; end
                        3: x_start = 16'd5;
                        4: begin
                            resetb = 1'b0;
                            #1;
                            chk("rst_dvo",  32'(pix.dvo),  32'd0);
                            chk("rst_lvo",  32'(pix.lvo),  32'd0);
                            chk("rst_fvo",  32'(pix.fvo),  32'd0);
                            chk("rst_dato", 32'(pix.dato), 32'd0);
                            chk("rst_fcnt", 32'(frame_count), 32'd0);
                            chk("rst_mw",   32'(meas_width),  32'd0);
                            @(negedge img_clk);
                            resetb = 1'b1;
                        end
                        default: ;
                    endcase
                end
                cyc(10'(l * 16 + p), 1'b1, 1'b1, 1'b1);
                if (p == 3) cyc(10'd0, 1'b0, 1'b1, 1'b1);
            end
            if (l == lines - 1 && simul) begin
                cyc(10'd0, 1'b0, 1'b0, 1'b0);
            end else begin
                cyc(10'd0, 1'b0, 1'b0, 1'b1);
                cyc(10'd0, 1'b0, 1'b0, 1'b1);
            end
        end
        if (!simul) cyc(10'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_win(input logic [15:0] xs, xl, ys, yl);
        x_start = xs; x_len = xl; y_start = ys; y_len = yl;
    endtask

    initial begin
        logic [9:0] v;
        resetb = 1'b0;
        enable = 1'b1;
        set_win(16'd0, 16'd0, 16'd0, 16'd0);
        pix.dati = '0; pix.dvi = 1'b0; pix.lvi = 1'b0; pix.fvi = 1'b0;
        repeat (3) @(posedge img_clk);
        #1;
        chk("reset_dato", 32'(pix.dato), 32'd0);
        chk("reset_dvo",  32'(pix.dvo),  32'd0);
        chk("reset_lvo",  32'(pix.lvo),  32'd0);
        chk("reset_fvo",  32'(pix.fvo),  32'd0);
        chk("reset_mw",   32'(meas_width),  32'd0);
        chk("reset_mh",   32'(meas_height), 32'd0);
        chk("reset_fcnt", 32'(frame_count), 32'd0);
        chk("reset_gv",   32'(geom_valid),  32'd0);
        @(negedge img_clk);
        resetb = 1'b1;

        // Full frame, 4 x 8, unwindowed, with per-cycle latency checks.
        chk_lat = 1'b1;
        run_frame(4, 8, 1'b0, -1, 0);
        chk_lat = 1'b0;
        chk("full_npix",  32'(n_dvo), 32'd32);
        chk("full_nline", 32'(n_lvo), 32'd4);
        chk("full_nfrm",  32'(n_fvo), 32'd1);
        v = outq[0];  chk("full_first", 32'(v), 32'd0);
        v = outq[31]; chk("full_last",  32'(v), 32'd55);
        chk("full_mw",   32'(meas_width),  32'd8);
        chk("full_mh",   32'(meas_height), 32'd4);
        chk("full_fcnt", 32'(frame_count), 32'd1);
        chk("full_gv",   32'(geom_valid),  32'd1);

        // Crop: lines 1..2, pixels 2..4.
        set_win(16'd2, 16'd3, 16'd1, 16'd2);
        run_frame(4, 8, 1'b0, -1, 0);
        chk("crop_npix",  32'(n_dvo), 32'd6);
        chk("crop_nline", 32'(n_lvo), 32'd2);
        v = outq[0]; chk("crop_first", 32'(v), 32'd18);
        v = outq[2]; chk("crop_l1end", 32'(v), 32'd20);
        v = outq[3]; chk("crop_l2beg", 32'(v), 32'd34);
        v = outq[5]; chk("crop_last",  32'(v), 32'd36);
        chk("crop_fcnt", 32'(frame_count), 32'd2);

        // Last line closes on the same cycle as the frame.
        set_win(16'd0, 16'd0, 16'd0, 16'd0);
        run_frame(3, 5, 1'b1, -1, 0);
        chk("simul_npix", 32'(n_dvo), 32'd15);
        chk("simul_mw",   32'(meas_width),  32'd5);
        chk("simul_mh",   32'(meas_height), 32'd3);
        chk("simul_fcnt", 32'(frame_count), 32'd3);

        // start+len would wrap in 16 bits.
        set_win(16'hFFFE, 16'hFFFF, 16'd0, 16'd0);
        run_frame(4, 8, 1'b0, -1, 0);
        chk("wrap_npix",  32'(n_dvo), 32'd0);
        chk("wrap_nline", 32'(n_lvo), 32'd4);
        chk("wrap_fcnt",  32'(frame_count), 32'd4);

        // Window entirely below the frame: fvo only.
        set_win(16'd0, 16'd0, 16'd10, 16'd0);
        run_frame(4, 8, 1'b0, -1, 0);
        chk("beyond_npix",  32'(n_dvo), 32'd0);
        chk("beyond_nline", 32'(n_lvo), 32'd0);
        chk("beyond_nfrm",  32'(n_fvo), 32'd1);
        chk("beyond_fcnt",  32'(frame_count), 32'd5);

        // Enable rises during line 2: frame ignored, next frame forwarded.
        set_win(16'd0, 16'd0, 16'd0, 16'd0);
        enable = 1'b0;
        run_frame(4, 8, 1'b0, 2, 1);
        chk("midon_npix", 32'(n_dvo), 32'd0);
        chk("midon_nfrm", 32'(n_fvo), 32'd0);
        chk("midon_fcnt", 32'(frame_count), 32'd5);
        run_frame(2, 4, 1'b0, -1, 0);
        chk("next_npix", 32'(n_dvo), 32'd8);
        chk("next_mw",   32'(meas_width),  32'd4);
        chk("next_mh",   32'(meas_height), 32'd2);
        chk("next_fcnt", 32'(frame_count), 32'd6);

        // Enable falls at line 1 pixel 2: line 0 plus pixel 0 of line 1 get through.
        run_frame(4, 8, 1'b0, 1, 2);
        chk("midoff_npix", 32'(n_dvo), 32'd9);
        chk("midoff_mw",   32'(meas_width),  32'd8);
        chk("midoff_mh",   32'(meas_height), 32'd2);
        chk("midoff_fcnt", 32'(frame_count), 32'd6);
        enable = 1'b1;

        // x_start changed mid-frame: latched window 2..4 still applies.
        set_win(16'd2, 16'd3, 16'd0, 16'd0);
        run_frame(2, 8, 1'b0, 0, 3);
        chk("cfg_npix", 32'(n_dvo), 32'd6);
        v = outq[0]; chk("cfg_first", 32'(v), 32'd2);
        v = outq[5]; chk("cfg_last",  32'(v), 32'd20);
        chk("cfg_fcnt", 32'(frame_count), 32'd7);

        // Reset during line 1; the rest of that frame must be ignored.
        set_win(16'd0, 16'd0, 16'd0, 16'd0);
        run_frame(3, 8, 1'b0, 1, 4);
        chk("rstfrm_npix", 32'(n_dvo), 32'd9);
        chk("rstfrm_nfrm", 32'(n_fvo), 32'd1);
        chk("rstfrm_fcnt", 32'(frame_count), 32'd0);
        chk("rstfrm_gv",   32'(geom_valid),  32'd0);
        run_frame(2, 4, 1'b0, -1, 0);
        chk("resume_npix", 32'(n_dvo), 32'd8);
        chk("resume_fcnt", 32'(frame_count), 32'd1);
        chk("resume_gv",   32'(geom_valid),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
